// File: rtl/seq_mon_pkg.sv
// ============================================================================
// Module      : seq_mon_pkg
// Description : Shared constants and trace-vector type for seq_trigger_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mon_pkg;

    localparam int DDD_LEN_MAX = 15;
    localparam int RUN_W       = 4;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } trace_t;

endpackage

`default_nettype wire

// File: rtl/seq_run_counter.sv
// ============================================================================
// Module      : seq_run_counter
// Description : Saturating consecutive-high run counter; met flags that the
//               current high sample completes a run of THRESH samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_run_counter #(
    parameter int THRESH = 3,
    parameter int RUN_W  = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic met
);

    localparam logic [RUN_W:0] c_thresh = (RUN_W + 1)'(THRESH);

    logic [RUN_W-1:0] r_run;
    logic [RUN_W:0]   w_inc;

    // One extra bit so the compare never wraps at the top of the range
    assign w_inc = {1'b0, r_run} + 1'b1;
    assign met   = din & (w_inc >= c_thresh);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= '0;
        end else if (!din) begin
            r_run <= '0;
        end else if (w_inc >= c_thresh) begin
            r_run <= c_thresh[RUN_W-1:0];
        end else begin
            r_run <= w_inc[RUN_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_trigger_monitor.sv
// ============================================================================
// Module      : seq_trigger_monitor
// Description : Tracks aac / cbb / ddd sequence end points and checks
//               "aac & cbb at t => ddd at t+1", with failure statistics.
//               Define SEQ_MON_COVER_EN to build the antecedent hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_trigger_monitor
    import seq_mon_pkg::*;
#(
    parameter int DDD_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             aac_trig,
    output logic             cbb_trig,
    output logic             ddd_trig,
    output logic             fail,
    output logic             fail_seen,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_cycle,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    trace_t           w_smp;
    logic             w_aac_now;
    logic             w_cbb_now;
    logic             w_ddd_now;
    logic             w_viol;

    logic             r_a_prev;
    logic             r_c_prev;
    logic             r_cbb_live;
    logic             r_pend;
    logic [CNT_W-1:0] r_cycle;

    assign w_smp = '{a: A, b: B, c: C, d: D};

    // A[+] ending at t-1 only needs A at t-1, so one history bit is enough
    assign w_aac_now = w_smp.c & r_a_prev;
    assign w_cbb_now = w_smp.b & (r_c_prev | r_cbb_live);
    assign w_viol    = r_pend & ~w_ddd_now;

    seq_run_counter #(
        .THRESH (DDD_LEN),
        .RUN_W  (RUN_W)
    ) u_ddd_run (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (w_smp.d),
        .met     (w_ddd_now)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_prev   <= 1'b0;
            r_c_prev   <= 1'b0;
            r_cbb_live <= 1'b0;
            r_pend     <= 1'b0;
            r_cycle    <= '0;
            aac_trig   <= 1'b0;
            cbb_trig   <= 1'b0;
            ddd_trig   <= 1'b0;
        end else begin
            r_a_prev   <= w_smp.a;
            r_c_prev   <= w_smp.c;
            r_cbb_live <= w_cbb_now;
            r_pend     <= w_aac_now & w_cbb_now;
            aac_trig   <= w_aac_now;
            cbb_trig   <= w_cbb_now;
            ddd_trig   <= w_ddd_now;
            if (r_cycle != c_cnt_max) begin
                r_cycle <= r_cycle + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fail             <= 1'b0;
            fail_seen        <= 1'b0;
            fail_count       <= '0;
            first_fail_cycle <= '0;
        end else begin
            fail <= w_viol;
            if (w_viol) begin
                fail_seen <= 1'b1;
                if (fail_count != c_cnt_max) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!fail_seen) begin
                    first_fail_cycle <= r_cycle;
                end
            end
        end
    end

`ifdef SEQ_MON_COVER_EN
    logic [CNT_W-1:0] r_hit_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_count <= '0;
        end else if (w_aac_now && w_cbb_now && (r_hit_count != c_cnt_max)) begin
            r_hit_count <= r_hit_count + 1'b1;
        end
    end

    assign hit_count = r_hit_count;
`else
    assign hit_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_trigger_monitor.sv
// ============================================================================
// Module      : tb_seq_trigger_monitor
// Description : Self-checking bench; three monitor configurations share one
//               stimulus stream and are compared against a history-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_trigger_monitor;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;

    logic       aac0, cbb0, ddd0, fail0, seen0;
    logic [7:0] fc0, ff0, hc0;
    logic       aac1, cbb1, ddd1, fail1, seen1;
    logic [1:0] fc1, ff1, hc1;
    logic       aac2, cbb2, ddd2, fail2, seen2;
    logic [7:0] fc2, ff2, hc2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    seq_trigger_monitor #(.DDD_LEN(3), .CNT_W(8)) u_dut (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B), .C(C), .D(D),
        .aac_trig(aac0), .cbb_trig(cbb0), .ddd_trig(ddd0), .fail(fail0),
        .fail_seen(seen0), .fail_count(fc0), .first_fail_cycle(ff0), .hit_count(hc0)
    );

    seq_trigger_monitor #(.DDD_LEN(3), .CNT_W(2)) u_sat (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B), .C(C), .D(D),
        .aac_trig(aac1), .cbb_trig(cbb1), .ddd_trig(ddd1), .fail(fail1),
        .fail_seen(seen1), .fail_count(fc1), .first_fail_cycle(ff1), .hit_count(hc1)
    );

    seq_trigger_monitor #(.DDD_LEN(1), .CNT_W(8)) u_l1 (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B), .C(C), .D(D),
        .aac_trig(aac2), .cbb_trig(cbb2), .ddd_trig(ddd2), .fail(fail2),
        .fail_seen(seen2), .fail_count(fc2), .first_fail_cycle(ff2), .hit_count(hc2)
    );

    // Reference model: raw sample history since the last reset
    bit hA [0:1023];
    bit hB [0:1023];
    bit hC [0:1023];
    bit hD [0:1023];
    int n_edges;

    int c_len [3] = '{3, 3, 1};
    int c_max [3] = '{255, 3, 255};

    bit e_aac, e_cbb;
    bit e_ddd  [3];
    bit e_fail [3];
    bit e_seen [3];
    int e_cnt  [3];
    int e_first[3];
    int e_hit  [3];

    function automatic bit aac_at(int t);
        return (t >= 1) && hC[t] && hA[t-1];
    endfunction

    // B must hold from just after some C up to t
    function automatic bit cbb_at(int t);
        if (t < 0 || !hB[t]) return 1'b0;
        for (int k = t - 1; k >= 0; k--) begin
            if (hC[k]) return 1'b1;
            if (!hB[k]) return 1'b0;
        end
        return 1'b0;
    endfunction

    function automatic bit ddd_at(int t, int len);
        if (t < len - 1) return 1'b0;
        for (int k = t - len + 1; k <= t; k++) begin
            if (!hD[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        n_edges = 0;
        e_aac   = 1'b0;
        e_cbb   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_ddd[i] = 1'b0; e_fail[i] = 1'b0; e_seen[i] = 1'b0;
            e_cnt[i] = 0;    e_first[i] = 0;   e_hit[i] = 0;
        end
    endtask

    task automatic model_push(input bit a, input bit b, input bit c, input bit d);
        int t;
        bit viol;
        t = n_edges;
        hA[t] = a; hB[t] = b; hC[t] = c; hD[t] = d;
        n_edges++;
        e_aac = aac_at(t);
        e_cbb = cbb_at(t);
        for (int i = 0; i < 3; i++) begin
            e_ddd[i]  = ddd_at(t, c_len[i]);
            viol      = (t >= 1) && aac_at(t - 1) && cbb_at(t - 1) && !e_ddd[i];
            e_fail[i] = viol;
            if (viol) begin
                if (!e_seen[i]) e_first[i] = (t < c_max[i]) ? t : c_max[i];
                e_seen[i] = 1'b1;
                if (e_cnt[i] < c_max[i]) e_cnt[i]++;
            end
            if (e_aac && e_cbb && e_hit[i] < c_max[i]) e_hit[i]++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string nm, input int i,
                              input logic aac, input logic cbb, input logic ddd,
                              input logic fl, input logic seen,
                              input logic [31:0] fc, input logic [31:0] ff,
                              input logic [31:0] hc);
        int t;
        int exp_hit;
        t = n_edges - 1;
`ifdef SEQ_MON_COVER_EN
        exp_hit = e_hit[i];
`else
        exp_hit = 0;
`endif
        check($sformatf("%s.aac_trig@%0d", nm, t), {31'd0, aac}, {31'd0, e_aac});
        check($sformatf("%s.cbb_trig@%0d", nm, t), {31'd0, cbb}, {31'd0, e_cbb});
        check($sformatf("%s.ddd_trig@%0d", nm, t), {31'd0, ddd}, {31'd0, e_ddd[i]});
        check($sformatf("%s.fail@%0d", nm, t), {31'd0, fl}, {31'd0, e_fail[i]});
        check($sformatf("%s.fail_seen@%0d", nm, t), {31'd0, seen}, {31'd0, e_seen[i]});
        check($sformatf("%s.fail_count@%0d", nm, t), fc, e_cnt[i]);
        check($sformatf("%s.first_fail@%0d", nm, t), ff, e_first[i]);
        check($sformatf("%s.hit_count@%0d", nm, t), hc, exp_hit);
    endtask

    task automatic check_all();
        check_inst("dut", 0, aac0, cbb0, ddd0, fail0, seen0, {24'd0, fc0}, {24'd0, ff0}, {24'd0, hc0});
        check_inst("sat", 1, aac1, cbb1, ddd1, fail1, seen1, {30'd0, fc1}, {30'd0, ff1}, {30'd0, hc1});
        check_inst("l1",  2, aac2, cbb2, ddd2, fail2, seen2, {24'd0, fc2}, {24'd0, ff2}, {24'd0, hc2});
    endtask

    task automatic step(input bit a, input bit b, input bit c, input bit d);
        A = a; B = b; C = c; D = d;
        model_push(a, b, c, d);
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        A = 1'b0; B = 1'b0; C = 1'b0; D = 1'b0;
        model_clear();
        @(posedge clock);
        @(negedge clock);
        check_all();
        reset_n = 1'b1;
    endtask

    // Asynchronous reset pulse inside the low clock phase; no edge is lost
    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        model_clear();
        check_all();
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_pattern(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                               input int c1, input int c2, input int d_lo, input int d_hi,
                               input int len, input int rst_at);
        do_reset();
        for (int t = 0; t < len; t++) begin
            if (t == rst_at) mid_reset();
            step(t >= a_lo && t <= a_hi, t >= b_lo && t <= b_hi,
                 t == c1 || t == c2, t >= d_lo && t <= d_hi);
        end
    endtask

    initial begin
        model_clear();

        // Pass case
        run_pattern(1, 12, 4, 13, 3, 13, 12, 14, 17, -1);
        check("pass.fail_count", {24'd0, fc0}, 0);

        // Failure case
        run_pattern(1, 12, 4, 13, 3, 13, 11, 13, 17, -1);
        check("failcase.fail_count", {24'd0, fc0}, 1);
        check("failcase.first_fail", {24'd0, ff0}, 14);

        // Vacuous case
        run_pattern(1, 12, 5, 13, 3, 13, 1, 0, 17, -1);
        check("vacuous.fail_seen", {31'd0, seen0}, 0);

        // Reset between edges 13 and 14
        run_pattern(1, 12, 4, 13, 3, 13, 11, 13, 17, 14);
        check("midrst.fail_seen", {31'd0, seen0}, 0);
        check("midrst.first_fail", {24'd0, ff0}, 0);

        // Six consecutive violations
        do_reset();
        for (int t = 0; t < 8; t++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("sat.fail_count", {30'd0, fc1}, 3);
        check("sat.first_fail", {30'd0, ff1}, 2);
        check("sat.dut_count", {24'd0, fc0}, 6);

        // DDD_LEN=1 with a single D at edge 14
        run_pattern(1, 12, 4, 13, 3, 13, 14, 14, 17, -1);
        check("len1.fail_seen", {31'd0, seen2}, 0);

        // Randomized segments with occasional mid-run resets
        for (int seg = 0; seg < 20; seg++) begin
            int len;
            int rst_at;
            len    = $urandom_range(60, 30);
            rst_at = ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 1) : -1;
            do_reset();
            for (int t = 0; t < len; t++) begin
                if (t == rst_at) mid_reset();
                step($urandom_range(9, 0) < 6, $urandom_range(9, 0) < 7,
                     $urandom_range(9, 0) < 4, $urandom_range(9, 0) < 6);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
